// File: rtl/fifo_stream_drain_pkg.sv
// rtl/fifo_stream_drain_pkg.sv - shared fifo constants, width helper and error-flag struct
package fifo_stream_drain_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 3;

  // Bits needed to count 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to index depth entries (at least one)
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Sticky error flags, shared with the FIFO wrappers
  typedef struct packed {
    logic overflow;
    logic unexpected;
  } fifo_err_t;

endpackage

// File: rtl/fifo_stream_drain_buf.sv
// rtl/fifo_stream_drain_buf.sv - stream_buf: DEPTH-entry circular buffer with push/pop/count
module stream_buf
  import fifo_stream_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap explicitly so DEPTH need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Next-state: clear wins; otherwise write at wr_ptr, read at rd_ptr, net count change
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is zeroed on reset so the head reads 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fifo_stream_drain.sv
// rtl/fifo_stream_drain.sv - FIFO pop/valid read port to valid/ready stream adapter
module fifo_stream_drain
  import fifo_stream_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fifo_empty,
  input  logic                       fifo_valid,
  input  logic [WIDTH-1:0]           fifo_rdata,
  output logic                       fifo_pop,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       overflow_err,
  output logic                       unexp_err
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head;
  logic             inflight_q, inflight_d;
  fifo_err_t        err_q, err_d;
  logic             full;
  logic             fill;
  logic             fire;
  logic             push_en;

  // Credit check uses only registered terms, so m_ready never reaches fifo_pop.
  // Popping during reset is pointless since the FIFO is reset alongside us.
  always_comb begin
    full       = (count == CW'(DEPTH));
    m_valid    = (count != '0) && !flush;
    fire       = m_valid && m_ready;
    fill       = fifo_valid && !flush;
    push_en    = fill && (!full || fire);
    fifo_pop   = !rst && !fifo_empty && !flush &&
                 (({1'b0, count} + (CW + 1)'(inflight_q)) < DEPTH_X);
    inflight_d = fifo_pop;
    err_d      = err_q;
    if (fill && full && !fire) begin
      err_d.overflow = 1'b1;
    end
    if (fifo_valid && !inflight_q) begin
      err_d.unexpected = 1'b1;
    end
  end

  // In-flight pop tracking and sticky error flags (flush leaves errors alone)
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      err_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  stream_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push_en),
    .push_data (fifo_rdata),
    .pop       (fire),
    .head_data (head),
    .count     (count)
  );

  assign m_data       = head;
  assign occupancy    = count;
  assign overflow_err = err_q.overflow;
  assign unexp_err    = err_q.unexpected;

endmodule
